// File: rtl/fpu_norm_pkg.sv
// +----------------------------------------------------------------------------+
// | fpu_norm_pkg                                                               |
// | Shared types and width helpers for the FPU normalisation datapath.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpu_norm_pkg;

  typedef enum logic {
    NORM_LZ = 1'b0,
    NORM_LS = 1'b1
  } norm_mode_e;

  // Count width able to hold the value WIDTH itself (all-zero LZ result).
  function automatic int calc_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_tree.sv
// +----------------------------------------------------------------------------+
// | lzc_tree                                                                   |
// | Combinational recursive leading-zero counter built from 4-bit leaves.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lzc_tree #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     all_zero
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH == 4) begin : g_leaf
    assign all_zero = (data == 4'b0000);
    assign count    = data[3] ? CW'(0) :
                      data[2] ? CW'(1) :
                      data[1] ? CW'(2) : CW'(3);
  end else begin : g_node
    localparam int HALF = WIDTH / 2;

    logic [CW-2:0] w_hi_cnt;
    logic [CW-2:0] w_lo_cnt;
    logic          w_hi_zero;
    logic          w_lo_zero;

    lzc_tree #(.WIDTH(HALF)) u_hi (
      .data     (data[WIDTH-1:HALF]),
      .count    (w_hi_cnt),
      .all_zero (w_hi_zero)
    );

    lzc_tree #(.WIDTH(HALF)) u_lo (
      .data     (data[HALF-1:0]),
      .count    (w_lo_cnt),
      .all_zero (w_lo_zero)
    );

    // An empty upper half contributes HALF zeros plus the lower half's count.
    assign count    = w_hi_zero ? {1'b1, w_lo_cnt} : {1'b0, w_hi_cnt};
    assign all_zero = w_hi_zero & w_lo_zero;
  end

endmodule

`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
// +----------------------------------------------------------------------------+
// | lzc_norm_pipe                                                              |
// | Two-stage leading-zero / leading-sign counter and normaliser, valid/ready. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lzc_norm_pipe
  import fpu_norm_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  TAG_W = 4,
  localparam int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  fpu_norm_pkg::norm_mode_e in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_zero,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHIFT_LVLS = $clog2(WIDTH);

  logic                  r_s1_valid;
  logic [WIDTH-1:0]      r_s1_data;
  logic [CNT_W-1:0]      r_s1_count;
  logic                  r_s1_zero;
  logic [TAG_W-1:0]      r_s1_tag;

  logic                  r_s2_valid;
  logic [WIDTH-1:0]      r_s2_data;
  logic [CNT_W-1:0]      r_s2_count;
  logic                  r_s2_zero;
  logic [TAG_W-1:0]      r_s2_tag;

  logic                  w_s1_load;
  logic                  w_s2_load;
  logic [WIDTH-2:0]      w_flip;
  logic [WIDTH-1:0]      w_tree_in;
  logic [CNT_W-2:0]      w_tree_cnt;
  logic                  w_tree_zero;
  logic [CNT_W-1:0]      w_count;
  logic [WIDTH-1:0]      w_shift [0:SHIFT_LVLS];

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  // Sign-count reduces to a zero-count of (x ^ sign) past the MSB; the padded
  // 1 caps the result at WIDTH-1 for all-zero and all-one operands.
  assign w_flip    = in_data[WIDTH-2:0] ^ {(WIDTH-1){in_data[WIDTH-1]}};
  assign w_tree_in = (in_mode == NORM_LS) ? {w_flip, 1'b1} : in_data;

  lzc_tree #(.WIDTH(WIDTH)) u_lzc (
    .data     (w_tree_in),
    .count    (w_tree_cnt),
    .all_zero (w_tree_zero)
  );

  assign w_count = w_tree_zero ? CNT_W'(WIDTH) : {1'b0, w_tree_cnt};

  // Count of WIDTH only occurs for a zero operand, so the low bits suffice.
  assign w_shift[0] = r_s1_data;
  for (genvar i = 0; i < SHIFT_LVLS; i++) begin : g_shift
    assign w_shift[i+1] = r_s1_count[i] ? (w_shift[i] << (1 << i)) : w_shift[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_count <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_count <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_tag   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data  <= in_data;
          r_s1_count <= w_count;
          r_s1_zero  <= (in_data == '0);
          r_s1_tag   <= in_tag;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data  <= w_shift[SHIFT_LVLS];
          r_s2_count <= r_s1_count;
          r_s2_zero  <= r_s1_zero;
          r_s2_tag   <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_count = r_s2_count;
  assign out_zero  = r_s2_zero;
  assign out_tag   = r_s2_tag;

endmodule

`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_lzc_norm_pipe                                                           |
// | Scoreboard bench: directed vectors, backpressure, reset flush, random run. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lzc_norm_pipe;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  fpu_norm_pkg::norm_mode_e in_mode;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [WIDTH-1:0]         out_data;
  logic [CNT_W-1:0]         out_count;
  logic                     out_zero;
  logic [TAG_W-1:0]         out_tag;

  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 0;
  bit   saw_stall;
  exp_t q[$];

  lzc_norm_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count bits from the MSB directly, then shift arithmetically.
  function automatic exp_t ref_model(input logic [WIDTH-1:0] d, input logic m,
                                     input logic [TAG_W-1:0] t);
    exp_t e;
    int   n = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i] != (m ? d[WIDTH-1] : 1'b0)) break;
      n++;
    end
    if (m) n = n - 1;
    e.count = CNT_W'(n);
    e.data  = (n >= WIDTH) ? '0 : d << n;
    e.zero  = (d == '0);
    e.tag   = t;
    return e;
  endfunction

  function automatic exp_t mk(input logic [WIDTH-1:0] d, input int c, input logic z,
                              input logic [TAG_W-1:0] t);
    exp_t e;
    e.data = d; e.count = CNT_W'(c); e.zero = z; e.tag = t;
    return e;
  endfunction

  // out_ready generator; applied 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold stability.
  logic             prev_hold;
  logic [WIDTH-1:0] prev_data;
  logic [TAG_W-1:0] prev_tag;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_tag", out_tag, prev_tag);
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got tag %0h data %0h expected no output", out_tag, out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_count", out_count, e.count);
          chk("out_zero", out_zero, e.zero);
          chk("out_tag", out_tag, e.tag);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                      input exp_t e);
    bit ok = 1'b0;
    in_data  = d;
    in_mode  = fpu_norm_pkg::norm_mode_e'(m);
    in_tag   = t;
    in_valid = 1'b1;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) q.push_back(e);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 1000 cycles");
    end
  endtask

  task automatic send_ref(input logic [WIDTH-1:0] d, input logic m, input logic [TAG_W-1:0] t);
    send(d, m, t, ref_model(d, m, t));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    for (int k = 0; k < 200 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    chk(name, q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = fpu_norm_pkg::NORM_LZ;
    in_tag   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single beat and its latency.
    send(16'h0010, 1'b0, 4'hA, mk(16'h8000, 11, 1'b0, 4'hA));
    in_valid = 1'b0;
    chk("lat_edge0", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge1", out_valid, 1);
    drain("drain_t1");

    // Directed boundary vectors.
    send(16'h0000, 1'b0, 4'h1, mk(16'h0000, 16, 1'b1, 4'h1));
    send(16'h8000, 1'b0, 4'h2, mk(16'h8000, 0,  1'b0, 4'h2));
    send(16'hFFF0, 1'b1, 4'h3, mk(16'h8000, 11, 1'b0, 4'h3));
    send(16'h0010, 1'b1, 4'h4, mk(16'h4000, 10, 1'b0, 4'h4));
    send(16'hFFFF, 1'b1, 4'h5, mk(16'h8000, 15, 1'b0, 4'h5));
    send(16'h0000, 1'b1, 4'h6, mk(16'h0000, 15, 1'b1, 4'h6));
    send(16'h4000, 1'b1, 4'h7, mk(16'h4000, 0,  1'b0, 4'h7));
    send(16'h0001, 1'b0, 4'h8, mk(16'h8000, 15, 1'b0, 4'h8));
    drain("drain_t3");

    // Back-to-back burst with a 3-cycle downstream stall.
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_ref(WIDTH'($urandom), i[0], TAG_W'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    chk("burst_stall_seen", saw_stall, 1);
    drain("drain_t4");

    // Reset with two beats held.
    rdy_mode = 2;
    send_ref(16'h0123, 1'b0, 4'h9);
    send_ref(16'hF00F, 1'b1, 4'hC);
    idle(2);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_tag", out_tag, 0);
    q.delete();
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    idle(5);
    chk("post_rst_no_stale", out_valid, 0);

    // Random run against the reference model.
    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [WIDTH-1:0] d;
      logic             m;
      d = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
      m = 1'($urandom);
      if (m && $urandom_range(0, 1) == 1) d = ~d;
      if ($urandom_range(0, 3) == 0) idle(1);
      send_ref(d, m, TAG_W'($urandom));
    end
    rdy_mode = 0;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
